// File: rtl/apb_mem_pkg.sv
// ---------------------------------------------------------------------------
// apb_mem_pkg
// Shared types and constants for the APB-to-memory-stage bridge.
//   state_t        bridge FSM states
//   ADDR_W/DATA_W  memory-stage word address and data widths
//   WRITE_EXTRA /
//   READ_EXTRA     cycles a transfer needs on top of the configured wait
//                  states (a read waits one cycle for registered mem_out)
//   extra_cycles() total extra access cycles for one transfer
// ---------------------------------------------------------------------------
package apb_mem_pkg;

    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 32;
    localparam int CNT_W       = 3;   // holds up to 3 wait states + 1 read cycle
    localparam int WRITE_EXTRA = 0;
    localparam int READ_EXTRA  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [CNT_W-1:0] extra_cycles(input int wait_cycles,
                                                      input logic is_write);
        return CNT_W'(wait_cycles + (is_write ? WRITE_EXTRA : READ_EXTRA));
    endfunction

endpackage

// File: rtl/apb_mem_wait_cnt.sv
// ---------------------------------------------------------------------------
// apb_mem_wait_cnt
// Loadable down-counter. A load sets the count; afterwards it decrements by
// one per cycle and stops at zero. o_done is high while the count is zero.
//   clk         clock
//   res         synchronous active-high reset
//   i_load      load i_load_val this cycle
//   i_load_val  value to load
//   o_done      count has reached zero
// ---------------------------------------------------------------------------
module apb_mem_wait_cnt
    import apb_mem_pkg::*;
(
    input  logic             clk,
    input  logic             res,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: clocked state is only ever assigned with <=, so every flop in the
    // design samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (res) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/apb_mem_bridge.sv
// ---------------------------------------------------------------------------
// apb_mem_bridge
// APB slave that forwards single-word transfers to an external memory stage
// with one-cycle registered read data.
//
// Ports
//   clk, res            clock, synchronous active-high reset
//   psel, penable,
//   pwrite, paddr,
//   pwdata              APB request (word index = paddr[8:2])
//   prdata, pready,
//   pslverr             APB response
//   mem_address,
//   mem_data_in,
//   mem_write_enable,
//   mem_pwrite          memory-stage request
//   mem_out             memory-stage read data (one cycle after address)
//
// Parameters
//   DEPTH        number of 32-bit words behind the bridge
//   WAIT_CYCLES  extra wait states (0..3) added to every transfer
//
// Build option
//   APB_MEM_SLVERR_EN   misaligned or out-of-range addresses answer with
//                       pslverr and never write; undefined, the word index
//                       simply wraps modulo DEPTH.
//
// Timing: the setup cycle is latched in IDLE. A transfer needing no extra
// cycles goes straight to RESP (the pready cycle); otherwise ACCESS/WAIT hold
// the address on the memory port until the wait counter expires.
// ---------------------------------------------------------------------------
module apb_mem_bridge
    import apb_mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              res,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    output logic              mem_pwrite,
    input  logic [DATA_W-1:0] mem_out
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;
    logic              r_err;

    logic              w_setup;
    logic              w_addr_err;
    logic              w_load;
    logic              w_cnt_done;
    logic [ADDR_W-1:0] w_index;
    logic [CNT_W-1:0]  w_extra;
    logic [CNT_W-1:0]  w_load_val;

    assign w_setup    = psel & ~penable;
    // Indices past DEPTH wrap back onto the array.
    assign w_index    = ADDR_W'(32'(paddr[8:2]) % DEPTH);
    assign w_extra    = extra_cycles(WAIT_CYCLES, pwrite);
    // ACCESS is itself the first extra cycle, so the counter runs one short.
    assign w_load_val = w_extra - CNT_W'(1);

`ifdef APB_MEM_SLVERR_EN
    assign w_addr_err = (paddr[1:0] != 2'b00) || (paddr >= 32'(DEPTH * 4));
`else
    logic w_unused_paddr;
    assign w_addr_err     = 1'b0;
    assign w_unused_paddr = &{1'b0, paddr[31:9], paddr[1:0]};
`endif

    apb_mem_wait_cnt u_wait_cnt (
        .clk        (clk),
        .res        (res),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_cnt_done)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_setup) begin
                r_addr  <= w_index;
                r_wdata <= pwdata;
                r_write <= pwrite;
                r_err   <= w_addr_err;
            end
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path through the block leaves a value held and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // penable without a preceding setup cycle falls through here.
                if (w_setup) begin
                    if (w_extra == '0) begin
                        w_state_next = ST_RESP;
                    end else begin
                        w_state_next = ST_ACCESS;
                        w_load       = 1'b1;
                    end
                end
            end
            ST_ACCESS, ST_WAIT: begin
                if (!psel) begin
                    w_state_next = ST_IDLE;
                end else if (w_cnt_done) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: the outputs are decoded from state and additionally forced to zero
    // while res is high, so the reset cycle itself can never emit a strobe or
    // a response, even if a transfer was about to complete.
    always_comb begin
        prdata           = '0;
        pready           = 1'b0;
        pslverr          = 1'b0;
        mem_address      = '0;
        mem_data_in      = '0;
        mem_write_enable = 1'b0;
        mem_pwrite       = 1'b0;
        if (!res) begin
            unique case (r_state)
                ST_ACCESS, ST_WAIT: begin
                    mem_address = r_addr;
                end
                ST_RESP: begin
                    mem_address = r_addr;
                    // A master that dropped psel gets no response and no commit.
                    if (psel) begin
                        pready  = 1'b1;
                        pslverr = r_err;
                        if (r_write && !r_err) begin
                            mem_pwrite       = 1'b1;
                            mem_write_enable = 1'b1;
                            mem_data_in      = r_wdata;
                        end else if (!r_write && !r_err) begin
                            prdata = mem_out;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_bridge
// Two bridges share one APB bus: device 0 with WAIT_CYCLES=0, device 1 with
// WAIT_CYCLES=3; dev selects which one sees psel. Each has its own model of
// the memory stage (64 words, registered read). Directed transfers with
// hand-computed expectations; a background monitor flags protocol breaches.
// ---------------------------------------------------------------------------
module tb_apb_mem_bridge;
    import apb_mem_pkg::*;

    logic        clk = 1'b0;
    logic        res;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    int          dev;

    logic        psel_d      [2];
    logic [31:0] prdata_d    [2];
    logic        pready_d    [2];
    logic        pslverr_d   [2];
    logic [6:0]  mem_addr_d  [2];
    logic [31:0] mem_din_d   [2];
    logic        mem_we_d    [2];
    logic        mem_pwr_d   [2];
    logic [31:0] mem_out_d   [2];
    logic [31:0] mem_m       [2][64];

    int n_checks = 0;
    int n_errors = 0;
    int strobes [2] = '{0, 0};
    int bad     [2] = '{0, 0};
    logic prev_rdy [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    always_comb begin
        psel_d[0] = psel && (dev == 0);
        psel_d[1] = psel && (dev == 1);
    end

    apb_mem_bridge #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .res(res), .psel(psel_d[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_d[0]), .pready(pready_d[0]), .pslverr(pslverr_d[0]),
        .mem_address(mem_addr_d[0]), .mem_data_in(mem_din_d[0]),
        .mem_write_enable(mem_we_d[0]), .mem_pwrite(mem_pwr_d[0]),
        .mem_out(mem_out_d[0])
    );

    apb_mem_bridge #(.DEPTH(64), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .res(res), .psel(psel_d[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_d[1]), .pready(pready_d[1]), .pslverr(pslverr_d[1]),
        .mem_address(mem_addr_d[1]), .mem_data_in(mem_din_d[1]),
        .mem_write_enable(mem_we_d[1]), .mem_pwrite(mem_pwr_d[1]),
        .mem_out(mem_out_d[1])
    );

    // Memory-stage model: write on strobe, read data registered one cycle.
    initial begin
        for (int d = 0; d < 2; d++) begin
            mem_out_d[d] = '0;
            for (int w = 0; w < 64; w++) mem_m[d][w] = '0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we_d[d]) mem_m[d][mem_addr_d[d][5:0]] <= mem_din_d[d];
            mem_out_d[d] <= mem_m[d][mem_addr_d[d][5:0]];
        end
    end

    // Protocol monitor: strobe only with pready, no back-to-back pready,
    // prdata zero outside pready, direction and strobe always together.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we_d[d]) strobes[d] <= strobes[d] + 1;
            if ((mem_we_d[d] && !pready_d[d]) ||
                (pready_d[d] && prev_rdy[d]) ||
                (!pready_d[d] && prdata_d[d] != '0) ||
                (mem_pwr_d[d] != mem_we_d[d]))
                bad[d] <= bad[d] + 1;
            prev_rdy[d] <= pready_d[d];
        end
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One APB transfer. cyc = access cycle in which pready was seen (0 when
    // the bound expires). Leaves the bus selected so another transfer may
    // follow without an idle cycle.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output int cyc,
                        output logic [31:0] rd, output logic err,
                        output logic [31:0] maddr, output logic we_at,
                        output logic [31:0] mdin);
        @(posedge clk); #1;
        dev = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0; rd = '0; err = 1'b0; maddr = '0; we_at = 1'b0; mdin = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (pready_d[d]) begin
                cyc   = i;
                rd    = prdata_d[d];
                err   = pslverr_d[d];
                maddr = 32'(mem_addr_d[d]);
                we_at = mem_we_d[d];
                mdin  = mem_din_d[d];
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    function automatic logic [31:0] outs_or(input int d);
        return prdata_d[d] | mem_din_d[d] | 32'(mem_addr_d[d]) |
               32'({pready_d[d], pslverr_d[d], mem_we_d[d], mem_pwr_d[d]});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, s, pr;
        logic [31:0] rd, ma, md;
        logic        err, we_at;

        // Reset with an active-looking setup on the bus: outputs stay zero.
        res = 1'b1; dev = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'h1111_1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outs_dev0", outs_or(0), 32'h0);
        check("rst_outs_dev1", outs_or(1), 32'h0);
        @(posedge clk); #1;
        res = 1'b0; psel = 1'b0;

        // Write 0x10 = DEADBEEF, no wait states.
        s = strobes[0];
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, cyc, rd, err, ma, we_at, md);
        check("wr_latency", 32'(cyc), 32'd1);
        check("wr_mem_addr", ma, 32'd4);
        check("wr_strobe_at_ready", 32'(we_at), 32'd1);
        check("wr_data", md, 32'hDEAD_BEEF);
        check("wr_no_slverr", 32'(err), 32'd0);
        bus_idle();
        check("wr_strobe_count", 32'(strobes[0] - s), 32'd1);

        // Read it back.
        s = strobes[0];
        xfer(0, 1'b0, 32'h10, 32'h0, cyc, rd, err, ma, we_at, md);
        check("rd_latency", 32'(cyc), 32'd2);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_no_strobe", 32'(we_at), 32'd0);
        bus_idle();
        check("rd_strobe_count", 32'(strobes[0] - s), 32'd0);

        // Back-to-back write then read of word 0, no idle cycle.
        xfer(0, 1'b1, 32'h0, 32'h1, cyc, rd, err, ma, we_at, md);
        check("b2b_wr_latency", 32'(cyc), 32'd1);
        xfer(0, 1'b0, 32'h0, 32'h0, cyc, rd, err, ma, we_at, md);
        check("b2b_rd_latency", 32'(cyc), 32'd2);
        check("b2b_rd_data", rd, 32'h1);
        bus_idle();

        // Three wait states.
        xfer(1, 1'b1, 32'h20, 32'hCAFE_F00D, cyc, rd, err, ma, we_at, md);
        check("w3_wr_latency", 32'(cyc), 32'd4);
        check("w3_wr_mem_addr", ma, 32'd8);
        bus_idle();
        xfer(1, 1'b0, 32'h20, 32'h0, cyc, rd, err, ma, we_at, md);
        check("w3_rd_latency", 32'(cyc), 32'd5);
        check("w3_rd_data", rd, 32'hCAFE_F00D);
        bus_idle();

        // psel dropped in access cycle 1 of a read: no response.
        @(posedge clk); #1;
        dev = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b1;
        pr = 0;
        repeat (4) begin
            @(negedge clk);
            if (pready_d[0]) pr++;
        end
        check("abort_no_ready", 32'(pr), 32'd0);
        penable = 1'b0;
        xfer(0, 1'b0, 32'h10, 32'h0, cyc, rd, err, ma, we_at, md);
        check("after_abort_rd_latency", 32'(cyc), 32'd2);
        check("after_abort_rd_data", rd, 32'hDEAD_BEEF);
        bus_idle();

        // Reset pulsed in access cycle 2 of a 3-wait-state write.
        s = strobes[1];
        @(posedge clk); #1;
        dev = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h30; pwdata = 32'h1234_5678;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        res = 1'b1;
        @(negedge clk);
        check("midrst_outs_dev1", outs_or(1), 32'h0);
        @(posedge clk); #1;
        res = 1'b0;
        // psel/penable stay high: penable without setup must be ignored.
        pr = 0;
        repeat (6) begin
            @(negedge clk);
            if (pready_d[1]) pr++;
        end
        check("midrst_no_ready", 32'(pr), 32'd0);
        psel = 1'b0; penable = 1'b0;
        check("midrst_no_strobe", 32'(strobes[1] - s), 32'd0);
        xfer(1, 1'b0, 32'h30, 32'h0, cyc, rd, err, ma, we_at, md);
        check("midrst_rd_latency", 32'(cyc), 32'd5);
        check("midrst_mem_unchanged", rd, 32'h0);
        bus_idle();

`ifdef APB_MEM_SLVERR_EN
        s = strobes[0];
        xfer(0, 1'b1, 32'h102, 32'h55, cyc, rd, err, ma, we_at, md);
        check("err_wr_latency", 32'(cyc), 32'd1);
        check("err_wr_slverr", 32'(err), 32'd1);
        check("err_wr_no_strobe", 32'(we_at), 32'd0);
        bus_idle();
        check("err_wr_strobe_count", 32'(strobes[0] - s), 32'd0);
        xfer(0, 1'b0, 32'h100, 32'h0, cyc, rd, err, ma, we_at, md);
        check("err_rd_slverr", 32'(err), 32'd1);
        check("err_rd_data_zero", rd, 32'h0);
        bus_idle();
        xfer(0, 1'b0, 32'h0, 32'h0, cyc, rd, err, ma, we_at, md);
        check("err_word0_unchanged", rd, 32'h1);
        check("err_word0_no_slverr", 32'(err), 32'd0);
        bus_idle();
`else
        xfer(0, 1'b1, 32'h100, 32'hA5A5_A5A5, cyc, rd, err, ma, we_at, md);
        check("wrap_wr_mem_addr", ma, 32'd0);
        check("wrap_wr_strobe", 32'(we_at), 32'd1);
        check("wrap_no_slverr", 32'(err), 32'd0);
        bus_idle();
        xfer(0, 1'b0, 32'h0, 32'h0, cyc, rd, err, ma, we_at, md);
        check("wrap_rd_word0", rd, 32'hA5A5_A5A5);
        bus_idle();
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("monitor_violations", 32'(bad[0] + bad[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_mem_bridge.md
APB_MEM_BRIDGE -- requirements
Module: apb_mem_bridge

Interface
REQ-001 Parameter DEPTH, 64, number of 32-bit memory words.
REQ-002 Parameter WAIT_CYCLES, 0, extra wait states (0..3) inserted before pready on every access.
REQ-003 Port clk  input  1  single clock; all logic on posedge.
REQ-004 Port res  input  1  reset, synchronous, active-high.
REQ-005 Port psel  input  1  APB slave select.
REQ-006 Port penable  input  1  APB access phase.
REQ-007 Port pwrite  input  1  APB direction, 1 = write.
REQ-008 Port paddr  input  32  APB byte address; word index = paddr[8:2].
REQ-009 Port pwdata  input  32  APB write data.
REQ-010 Port prdata  output  32  APB read data.
REQ-011 Port pready  output  1  APB transfer complete.
REQ-012 Port pslverr  output  1  APB error response.
REQ-013 Port mem_address  output  7  word address to the memory stage.
REQ-014 Port mem_data_in  output  32  write data to the memory stage.
REQ-015 Port mem_write_enable  output  1  write strobe to the memory stage.
REQ-016 Port mem_pwrite  output  1  direction to the memory stage; high = write, low = read.
REQ-017 Port mem_out  input  32  registered read data from the memory stage, valid one cycle after address is presented with mem_pwrite low.

Function
REQ-018 FSM states: IDLE, ACCESS, WAIT, RESP.
REQ-019 IDLE: on psel=1 & penable=0, latch paddr[8:2], pwdata and pwrite, then go to ACCESS; all other inputs are ignored.
REQ-020 ACCESS/WAIT: drive mem_address = latched index and mem_pwrite = 0. Count WAIT_CYCLES cycles, then go to RESP. A write needs 0 extra cycles. A read needs 1 extra cycle for mem_out latency.
REQ-021 Write latency: pready=1 on APB access cycle WAIT_CYCLES+1. Read latency: pready=1 on access cycle WAIT_CYCLES+2.
REQ-022 Write commit: mem_pwrite=1 and mem_write_enable=1 for exactly the single cycle in which pready=1; mem_data_in = latched pwdata. Both are 0 in every other cycle.
REQ-023 Read response: prdata = mem_out only while pready=1 for a read; otherwise prdata = 0.
REQ-024 After the pready cycle, return to IDLE. A setup phase in the next cycle starts a new transfer, so back-to-back transfers are supported.
REQ-025 psel deasserted before pready: abort to IDLE next cycle; no memory write occurs; pready stays 0.
REQ-026 penable=1 seen in IDLE without a prior setup phase: ignored; no response.
REQ-027 pready, pslverr and the mem strobes are never asserted for more than one consecutive cycle per transfer.

Reset
REQ-028 While res=1 at a posedge: state=IDLE, latched registers=0, and all outputs=0 (prdata, pready, pslverr, mem_address, mem_data_in, mem_write_enable, mem_pwrite).
REQ-029 Reset mid-transfer discards the transfer; no write strobe is issued in or after the reset cycle.

Configuration
REQ-030 Macro APB_MEM_SLVERR_EN defined: paddr[1:0]!=0 or paddr >= DEPTH*4 gives pslverr=1 in the pready cycle, with the write strobe suppressed and prdata=0.
REQ-031 Macro APB_MEM_SLVERR_EN undefined: pslverr tied 0; address is taken as paddr[8:2] only (upper bits ignored, wrap-around); no suppression.

Structure
REQ-032 Package apb_mem_pkg holds: state enum, ADDR_W=7, DATA_W=32, and the latency constants.
REQ-033 One sub-module, apb_mem_wait_cnt: loadable down-counter producing a done flag, instantiated once.

Verification
REQ-034 Write paddr=0x10, pwdata=0xDEADBEEF, WAIT_CYCLES=0 -> pready on access cycle 1; mem_address=4; single-cycle write strobe with data 0xDEADBEEF.
REQ-035 Read paddr=0x10 after REQ-034 -> pready on access cycle 2; prdata=0xDEADBEEF; no write strobe.
REQ-036 WAIT_CYCLES=3: write -> pready on cycle 4; read -> pready on cycle 5.
REQ-037 Back-to-back write 0x0=0x1, then read 0x0 with no idle cycle between -> prdata=0x1.
REQ-038 psel dropped in access cycle 1 of a read; res pulsed mid-write -> no strobe, pready=0, all outputs 0 after reset.
REQ-039 APB_MEM_SLVERR_EN defined, write paddr=0x102 -> pslverr=1 with pready, memory unchanged; undefined: paddr=0x100 writes word 0.
